// File: rtl/multicycle_ctrl_fsm.sv
// Main control sequencer of the multi-cycle CPU: one instruction at a time over a shared datapath.
// Halts on an illegal opcode or a memory access that stalls for longer than MAX_WAIT cycles.
module multicycle_ctrl_fsm #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       halted,
  output logic [1:0] err_code,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_RD    = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_HALT      = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               is_lw_q, is_lw_d;
  logic [1:0]         err_q, err_d;
  logic               halted_q, halted_d;
  logic               mem_state;
  logic               timeout;

  // Stall accounting shared by the three memory-access states.
  always_comb begin
    mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    timeout   = mem_state && !mem_ready && (wait_q == WAIT_W'(MAX_WAIT));
    wait_d    = (mem_state && !mem_ready && !timeout) ? wait_q + WAIT_W'(1) : '0;
  end

  // Next-state and control decode; the FETCH write enables follow mem_ready combinationally.
  always_comb begin
    state_d       = state_q;
    is_lw_d       = is_lw_q;
    err_d         = err_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = 2'd0;
    pc_source     = 2'd0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end
      end

      S_DECODE: begin
        alu_src_b = 2'd3;
        is_lw_d   = (opcode == OP_LW);
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          default: begin
            state_d = S_HALT;
            err_d   = ERR_ILLEGAL;
          end
        endcase
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = is_lw_q ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (timeout) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end
      end

      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
        state_d   = S_R_WB;
      end

      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'd1;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
        state_d       = S_FETCH;
      end

      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'd2;
        state_d   = S_FETCH;
      end

      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = S_ADDI_WB;
      end

      S_ADDI_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_HALT;
    endcase

    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      is_lw_q  <= 1'b0;
      err_q    <= ERR_NONE;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      is_lw_q  <= is_lw_d;
      err_q    <= err_d;
      halted_q <= halted_d;
    end
  end

  assign state    = state_q;
  assign err_code = err_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized instruction streams against a per-instruction cycle model; expected cycles are
// queued by the driver and popped by an independent monitor on the falling edge.
module tb_multicycle_ctrl_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, asa;
    logic [1:0] asb, aop, psrc;
    logic       hlt;
    logic [1:0] err;
  } exp_t;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_J = 4, K_ADDI = 5, K_ILL = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, halted;
  logic [1:0] alu_src_b, alu_op, pc_source, err_code;
  logic [3:0] state;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  multicycle_ctrl_fsm #(.MAX_WAIT(15), .WAIT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .halted(halted), .err_code(err_code), .state(state)
  );

  always #5 clk = ~clk;

  function automatic exp_t sample();
    exp_t a;
    a.st = state; a.pcw = pc_write; a.pcwc = pc_write_cond; a.iord = i_or_d;
    a.mrd = mem_read; a.mwr = mem_write; a.irw = ir_write; a.rdst = reg_dst;
    a.m2r = mem_to_reg; a.rw = reg_write; a.asa = alu_src_a; a.asb = alu_src_b;
    a.aop = alu_op; a.psrc = pc_source; a.hlt = halted; a.err = err_code;
    return a;
  endfunction

  function automatic exp_t base(input logic [3:0] st);
    exp_t e = '0;
    e.st = st;
    return e;
  endfunction

  function automatic logic [5:0] rnd6();
    return 6'($urandom);
  endfunction

  function automatic logic rnd1();
    return 1'($urandom);
  endfunction

  function automatic logic legal(input logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
  endfunction

  function automatic logic [5:0] op_of(input int kind, input logic [5:0] ill);
    case (kind)
      K_LW:    return 6'b100011;
      K_SW:    return 6'b101011;
      K_R:     return 6'b000000;
      K_BEQ:   return 6'b000100;
      K_J:     return 6'b000010;
      K_ADDI:  return 6'b001000;
      default: return ill;
    endcase
  endfunction

  task automatic cmp(input string name, input exp_t a, input exp_t e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h (state %0d) want %h (state %0d)", name, $time, a, a.st, e, e.st);
    end
  endtask

  // One clock of stimulus plus the response the model expects for it.
  task automatic step(input logic [5:0] op, input logic rdy, input exp_t e);
    @(posedge clk);
    #1;
    opcode    = op;
    mem_ready = rdy;
    exp_q.push_back(e);
  endtask

  task automatic halt_cycles(input logic [1:0] err, input int n);
    exp_t e;
    e = base(4'd15);
    e.hlt = 1'b1;
    e.err = err;
    for (int i = 0; i < n; i++) step(rnd6(), rnd1(), e);
  endtask

  // A memory wait of 16 or more stall cycles ends in a timeout halt.
  task automatic mem_wait(input exp_t stall, input exp_t done, input int waits, output logic hit);
    hit = 1'b0;
    for (int i = 0; i < waits && i < 16; i++) step(rnd6(), 1'b0, stall);
    if (waits >= 16) begin
      hit = 1'b1;
      halt_cycles(2'd2, 20);
    end else begin
      step(rnd6(), 1'b1, done);
    end
  endtask

  task automatic instr(input int kind, input int fw, input int mw, input logic [5:0] ill,
                       output logic stop);
    exp_t e, d;
    stop = 1'b0;
    e = base(4'd1); e.mrd = 1'b1; e.asb = 2'd1;
    d = e; d.irw = 1'b1; d.pcw = 1'b1;
    mem_wait(e, d, fw, stop);
    if (!stop) begin
      e = base(4'd2); e.asb = 2'd3;
      step(op_of(kind, ill), rnd1(), e);
      case (kind)
        K_LW, K_SW: begin
          e = base(4'd3); e.asa = 1'b1; e.asb = 2'd2;
          step(rnd6(), rnd1(), e);
          if (kind == K_LW) begin
            e = base(4'd4); e.mrd = 1'b1; e.iord = 1'b1;
          end else begin
            e = base(4'd6); e.mwr = 1'b1; e.iord = 1'b1;
          end
          mem_wait(e, e, mw, stop);
          if (!stop && kind == K_LW) begin
            e = base(4'd5); e.rw = 1'b1; e.m2r = 1'b1;
            step(rnd6(), rnd1(), e);
          end
        end
        K_R: begin
          e = base(4'd7); e.asa = 1'b1; e.aop = 2'd2;
          step(rnd6(), rnd1(), e);
          e = base(4'd8); e.rw = 1'b1; e.rdst = 1'b1;
          step(rnd6(), rnd1(), e);
        end
        K_BEQ: begin
          e = base(4'd9); e.asa = 1'b1; e.aop = 2'd1; e.pcwc = 1'b1; e.psrc = 2'd1;
          step(rnd6(), rnd1(), e);
        end
        K_J: begin
          e = base(4'd10); e.pcw = 1'b1; e.psrc = 2'd2;
          step(rnd6(), rnd1(), e);
        end
        K_ADDI: begin
          e = base(4'd11); e.asa = 1'b1; e.asb = 2'd2;
          step(rnd6(), rnd1(), e);
          e = base(4'd12); e.rw = 1'b1;
          step(rnd6(), rnd1(), e);
        end
        default: begin
          stop = 1'b1;
          halt_cycles(2'd1, 22);
        end
      endcase
    end
  endtask

  // Asynchronous reset in the middle of a cycle; optionally confirms a write was in flight.
  task automatic do_reset(input logic chk_wr);
    exp_t a;
    @(posedge clk);
    #2;
    if (chk_wr) begin
      a = sample();
      n_cmp++;
      if (a.mwr !== 1'b1) begin
        n_bad++;
        $display("FAIL pre_reset_mem_write: got %b want 1", a.mwr);
      end
    end
    #1 rst_n = 1'b0;
    #1 cmp("reset_async", sample(), base(4'd0));
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    opcode    = rnd6();
    mem_ready = rnd1();
    exp_q.push_back(base(4'd0));
  endtask

  task automatic sw_abort();
    exp_t e, d;
    logic stop;
    e = base(4'd1); e.mrd = 1'b1; e.asb = 2'd1;
    d = e; d.irw = 1'b1; d.pcw = 1'b1;
    mem_wait(e, d, 0, stop);
    e = base(4'd2); e.asb = 2'd3;
    step(6'b101011, 1'b1, e);
    e = base(4'd3); e.asa = 1'b1; e.asb = 2'd2;
    step(rnd6(), 1'b1, e);
    e = base(4'd6); e.mwr = 1'b1; e.iord = 1'b1;
    step(rnd6(), 1'b0, e);
    step(rnd6(), 1'b0, e);
    do_reset(1'b1);
  endtask

  function automatic int rand_wait();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return 0;
    if (r < 9) return int'($urandom_range(1, 4));
    return int'($urandom_range(13, 16));
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cmp($sformatf("cycle_st%0d", e.st), sample(), e);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : driver
    logic       stop;
    logic [5:0] ill;
    int         kind;
    rst_n = 1'b0; opcode = 6'd0; mem_ready = 1'b0;

    do_reset(1'b0);
    instr(K_R,   0, 0, 6'd0, stop);
    instr(K_LW,  0, 3, 6'd0, stop);
    instr(K_BEQ, 0, 0, 6'd0, stop);
    instr(K_J,   0, 0, 6'd0, stop);
    instr(K_ILL, 0, 0, 6'b111111, stop);

    do_reset(1'b0);
    instr(K_R,    15, 0, 6'd0, stop);
    instr(K_SW,   0, 15, 6'd0, stop);
    instr(K_ADDI, 2, 0, 6'd0, stop);
    instr(K_R,    16, 0, 6'd0, stop);

    do_reset(1'b0);
    instr(K_LW, 0, 16, 6'd0, stop);
    do_reset(1'b0);
    instr(K_SW, 1, 16, 6'd0, stop);

    do_reset(1'b0);
    sw_abort();
    instr(K_J, 0, 0, 6'd0, stop);

    for (int seg = 0; seg < 8; seg++) begin
      do_reset(1'b0);
      stop = 1'b0;
      for (int k = 0; k < 14 && !stop; k++) begin
        kind = ($urandom_range(0, 19) == 0) ? K_ILL : int'($urandom_range(0, 5));
        do ill = rnd6(); while (legal(ill));
        instr(kind, rand_wait(), rand_wait(), ill, stop);
      end
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected cycles left unchecked", exp_q.size());
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
